ram_dma_ctrl: RTL

Sequencing controller that sits directly upstream of the 32×32 synchronous RAM. It drives the RAM's address, write-data and write-enable, and consumes its registered read data. It executes one command at a time: FILL a word range with a constant, COPY a range to another base address, or SUM a range into a 32-bit checksum. It turns single `start` pulses from the host logic into correctly timed RAM cycles.

---
 rtl/ram_pkg.sv | 22 ++
 rtl/ram_dma_ctrl_if.sv | 21 ++
 rtl/ram_addr_gen.sv | 37 +++
 rtl/ram_dma_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared widths, op encodings and controller state type for the RAM sequencing controller.
package ram_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W + 1)'(DEPTH);

    localparam logic [1:0] OP_FILL = 2'b00;
    localparam logic [1:0] OP_COPY = 2'b01;
    localparam logic [1:0] OP_SUM  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RD,
        WR,
        SUMRD,
        SUMDRAIN,
        FIN
    } state_t;
endpackage

// File: rtl/ram_dma_ctrl_if.sv
// RAM port bundle: the controller is the master, the RAM is the slave.
interface ram_dma_ctrl_if;
    logic [ram_pkg::ADDR_W-1:0] mem_address;
    logic [ram_pkg::DATA_W-1:0] mem_data_in;
    logic                       mem_writeOn;
    logic [ram_pkg::DATA_W-1:0] mem_data_out;

    modport master (
        output mem_address,
        output mem_data_in,
        output mem_writeOn,
        input  mem_data_out
    );

    modport slave (
        input  mem_address,
        input  mem_data_in,
        input  mem_writeOn,
        output mem_data_out
    );
endinterface

// File: rtl/ram_addr_gen.sv
// Base + running index address generator with modulo-depth wrap and a last-word flag.
module ram_addr_gen
    import ram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [ADDR_W-1:0] base_in,
    input  logic [ADDR_W:0]   len_in,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W:0]   len_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            idx_q  <= '0;
            len_q  <= '0;
        end else if (load) begin
            base_q <= base_in;
            len_q  <= len_in;
            idx_q  <= '0;
        end else if (step) begin
            idx_q  <= idx_q + 1'b1;
        end
    end

    // Address width truncation gives the wrap from DEPTH-1 back to 0.
    assign addr = base_q + idx_q;
    assign last = ({1'b0, idx_q} == (len_q - 1'b1));

endmodule

// File: rtl/ram_dma_ctrl.sv
// Single-command RAM sequencer: FILL, COPY and SUM over a wrapping word range.
// states: IDLE wait | FILL write const | RD/WR copy pair | SUMRD read+acc | SUMDRAIN last add | FIN done
module ram_dma_ctrl
    import ram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W:0]   len,
    input  logic [DATA_W-1:0] fill_val,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] sum,
    ram_dma_ctrl_if.master    mem
);

    state_t            state;
    logic [DATA_W-1:0] fill_q;
    logic [DATA_W-1:0] acc;
    logic              acc_en;

    logic              cmd_load;
    logic              cmd_bad;
    logic              src_step;
    logic              dst_step;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic              src_last;
    logic              dst_last;

    assign cmd_load = (state == IDLE) && start;
    assign cmd_bad  = (op == 2'b11) || (len > LEN_MAX);
    assign src_step = (state == WR) || (state == SUMRD);
    assign dst_step = (state == FILL) || (state == WR);

    ram_addr_gen u_src_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (cmd_load),
        .step    (src_step),
        .base_in (src),
        .len_in  (len),
        .addr    (src_addr),
        .last    (src_last)
    );

    ram_addr_gen u_dst_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (cmd_load),
        .step    (dst_step),
        .base_in (dst),
        .len_in  (len),
        .addr    (dst_addr),
        .last    (dst_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            sum    <= '0;
            fill_q <= '0;
            acc    <= '0;
            acc_en <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        fill_q <= fill_val;
                        acc    <= '0;
                        acc_en <= 1'b0;
                        if (cmd_bad) begin
                            err <= 1'b1;
                        end else begin
                            busy <= 1'b1;
                            if (len == '0) begin
                                state <= FIN;
                                done  <= 1'b1;
                                if (op == OP_SUM) sum <= '0;
                            end else begin
                                case (op)
                                    OP_FILL: state <= FILL;
                                    OP_COPY: state <= RD;
                                    default: state <= SUMRD;
                                endcase
                            end
                        end
                    end
                end
                FILL: begin
                    if (dst_last) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end
                RD: state <= WR;
                WR: begin
                    if (dst_last) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        state <= RD;
                    end
                end
                SUMRD: begin
                    // RAM data lags the address by one cycle, so the first read has nothing to add yet.
                    acc_en <= 1'b1;
                    if (acc_en) acc <= acc + mem.mem_data_out;
                    if (src_last) state <= SUMDRAIN;
                end
                SUMDRAIN: begin
                    sum   <= acc + mem.mem_data_out;
                    state <= FIN;
                    done  <= 1'b1;
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        mem.mem_address = '0;
        mem.mem_data_in = '0;
        mem.mem_writeOn = 1'b0;
        case (state)
            FILL: begin
                mem.mem_address = dst_addr;
                mem.mem_data_in = fill_q;
                mem.mem_writeOn = 1'b1;
            end
            RD: begin
                mem.mem_address = src_addr;
            end
            WR: begin
                mem.mem_address = dst_addr;
                mem.mem_data_in = mem.mem_data_out;
                mem.mem_writeOn = 1'b1;
            end
            SUMRD: begin
                mem.mem_address = src_addr;
            end
            default: begin
                mem.mem_address = '0;
            end
        endcase
    end

endmodule
